// File: rtl/step_ctrl_pkg.sv
// Shared types and defaults for the run/step controller.
// Holds the FSM state encoding and the default debounce/burst sizing.
// No logic; imported by step_ctrl and debouncer.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    localparam int DB_CYCLES_DEF = 50000;
    localparam int DB_W_DEF      = 16;
    localparam int BURST_W_DEF   = 8;

endpackage

// File: rtl/step_ctrl_debouncer.sv
// Purpose: 2-flop synchroniser, stability-counter debouncer and rising-edge detector.
// Latency: raw high first sampled at posedge k -> db high after posedge k+1+DB_CYCLES.
// Backpressure: none; free-running per-cycle filter.
// Ports: clock/reset (async active-high), in (raw), db (debounced level), rise (1-cycle pulse).
module debouncer
    import step_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int DB_W      = DB_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic db,
    output logic rise
);

    localparam logic [DB_W-1:0] LAST = DB_W'(DB_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_db;
    logic            r_db_prev;
    logic [DB_W-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_db      <= 1'b0;
            r_db_prev <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= in;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            // Any sample agreeing with the debounced level restarts the run.
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign db   = r_db;
    assign rise = r_db & ~r_db_prev;

endmodule

// File: rtl/step_ctrl.sv
// Purpose: turns raw mode/step/burst board inputs into a registered single-domain core enable.
// Latency: cpu_en follows a debounced edge by one cycle (raw -> cpu_en = DB_CYCLES+2 posedges).
// Backpressure: none; edges arriving during a burst or in free run are dropped, not queued.
// Ports: clock, reset (async active-high), change_in/step_in/burst_in (raw), burst_len,
//        cpu_en, step_mode, busy, en_count (cycles with cpu_en=1, wrapping).
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int DB_W      = DB_W_DEF,
    parameter int BURST_W   = BURST_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               change_in,
    input  logic               step_in,
    input  logic               burst_in,
    input  logic [BURST_W-1:0] burst_len,
    output logic               cpu_en,
    output logic               step_mode,
    output logic               busy,
    output logic [31:0]        en_count
);

    logic w_mode_db, w_mode_rise;
    logic w_step_db, w_step_rise;
    logic w_burst_db, w_burst_rise;
    logic w_unused_ok;

    debouncer #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_change (
        .clock(clock), .reset(reset), .in(change_in), .db(w_mode_db), .rise(w_mode_rise)
    );
    debouncer #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_step (
        .clock(clock), .reset(reset), .in(step_in), .db(w_step_db), .rise(w_step_rise)
    );
    debouncer #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_burst (
        .clock(clock), .reset(reset), .in(burst_in), .db(w_burst_db), .rise(w_burst_rise)
    );

    // Only the mode level and the step/burst edges drive the controller.
    assign w_unused_ok = &{w_mode_rise, w_step_db, w_burst_db};

    state_t             r_state, w_state_nxt;
    logic               r_cpu_en, w_cpu_en_nxt;
    logic               r_busy, w_busy_nxt;
    logic [BURST_W-1:0] r_rem, w_rem_nxt;
    logic [31:0]        r_en_count;
    logic               w_burst_go;

    assign w_burst_go = w_burst_rise && (burst_len != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FREE;
            r_cpu_en   <= 1'b0;
            r_busy     <= 1'b0;
            r_rem      <= '0;
            r_en_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cpu_en <= w_cpu_en_nxt;
            r_busy   <= w_busy_nxt;
            r_rem    <= w_rem_nxt;
            if (r_cpu_en) begin
                r_en_count <= r_en_count + 32'd1;
            end
        end
    end

    // Leaving step mode wins over every state, including an in-flight burst.
    always_comb begin
        w_state_nxt = r_state;
        if (!w_mode_db) begin
            w_state_nxt = ST_FREE;
        end else begin
            case (r_state)
                ST_FREE:  w_state_nxt = ST_IDLE;
                ST_IDLE:  if (w_burst_go) w_state_nxt = ST_BURST;
                ST_BURST: if (r_rem == '0) w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_FREE;
            endcase
        end
    end

    // rem counts enables still owed after the current one, so burst_len-1 is loaded
    // on the edge cycle that itself raises cpu_en.
    always_comb begin
        w_cpu_en_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_rem_nxt    = '0;
        if (!w_mode_db) begin
            w_cpu_en_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_FREE: w_cpu_en_nxt = 1'b1;
                ST_IDLE: begin
                    if (w_burst_go) begin
                        w_cpu_en_nxt = 1'b1;
                        w_busy_nxt   = 1'b1;
                        w_rem_nxt    = burst_len - BURST_W'(1);
                    end else if (w_step_rise) begin
                        w_cpu_en_nxt = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (r_rem != '0) begin
                        w_cpu_en_nxt = 1'b1;
                        w_busy_nxt   = 1'b1;
                        w_rem_nxt    = r_rem - BURST_W'(1);
                    end
                end
                default: w_cpu_en_nxt = 1'b0;
            endcase
        end
    end

    assign cpu_en    = r_cpu_en;
    assign step_mode = w_mode_db;
    assign busy      = r_busy;
    assign en_count  = r_en_count;

endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl with DB_CYCLES=4: directed scenarios plus randomized inputs,
// all outputs compared every cycle against a behavioural model of the enable rules.
module tb_step_ctrl;

    localparam int DB = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        change_in, step_in, burst_in;
    logic [7:0]  burst_len;
    logic        cpu_en, step_mode, busy;
    logic [31:0] en_count;

    int n_checks = 0;
    int n_errors = 0;

    step_ctrl #(.DB_CYCLES(DB), .DB_W(16), .BURST_W(8)) dut (
        .clock(clock), .reset(reset), .change_in(change_in), .step_in(step_in),
        .burst_in(burst_in), .burst_len(burst_len), .cpu_en(cpu_en),
        .step_mode(step_mode), .busy(busy), .en_count(en_count)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // ---------------- reference model ----------------
    // Debounce: raw value reaches the filter two edges late; the level flips after DB
    // consecutive disagreeing samples. Enable: free run, idle, or a burst with a number
    // of enable cycles still owed.
    bit          m_d1[3], m_d2[3], m_db[3], m_dbp[3];
    int          m_run[3];
    bit          m_free = 1'b1;
    bit          m_inb, m_en, m_busy;
    int          m_left;
    logic [31:0] m_cnt = '0;

    initial begin
        bit raw[3];
        bit sm, srise, brise;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                for (int i = 0; i < 3; i++) begin
                    m_d1[i] = 0; m_d2[i] = 0; m_db[i] = 0; m_dbp[i] = 0; m_run[i] = 0;
                end
                m_free = 1; m_inb = 0; m_en = 0; m_busy = 0; m_left = 0; m_cnt = '0;
            end else begin
                raw[0] = change_in; raw[1] = step_in; raw[2] = burst_in;
                sm    = m_db[0];
                srise = m_db[1] && !m_dbp[1];
                brise = m_db[2] && !m_dbp[2];
                if (m_en) m_cnt = m_cnt + 32'd1;
                if (!sm) begin
                    m_en = 1; m_busy = 0; m_inb = 0; m_left = 0; m_free = 1;
                end else if (m_free) begin
                    m_en = 1; m_free = 0;
                end else if (m_inb) begin
                    if (m_left > 0) begin
                        m_en = 1; m_left--;
                    end else begin
                        m_en = 0; m_busy = 0; m_inb = 0;
                    end
                end else if (brise && burst_len != 0) begin
                    m_en = 1; m_busy = 1; m_inb = 1; m_left = int'(burst_len) - 1;
                end else begin
                    m_en = srise;
                end
                for (int i = 0; i < 3; i++) begin
                    m_dbp[i] = m_db[i];
                    if (m_d2[i] != m_db[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DB) begin
                            m_db[i]  = m_d2[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                    m_d2[i] = m_d1[i];
                    m_d1[i] = raw[i];
                end
            end
        end
    end

    initial forever begin
        @(negedge clock);
        chk("cpu_en", {31'd0, cpu_en}, {31'd0, m_en});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("step_mode", {31'd0, step_mode}, {31'd0, m_db[0]});
        chk("en_count", en_count, m_cnt);
    end

    // ---------------- stimulus ----------------
    int base, highs, bhigh, runs, first, lows;
    bit prev;
    int h_chg = 0, h_stp = 0, h_bst = 0;

    task automatic burst_window(input int n, input int release_at,
                                output int o_highs, output int o_bhigh, output int o_runs);
        bit p;
        o_highs = 0; o_bhigh = 0; o_runs = 0; p = 0;
        for (int j = 0; j < n; j++) begin
            @(posedge clock); #2;
            if (cpu_en) o_highs++;
            if (busy) o_bhigh++;
            if (cpu_en && !p) o_runs++;
            p = cpu_en;
            if (j == release_at) begin
                burst_in = 0; step_in = 0;
            end
        end
    endtask

    initial begin
        reset = 1; change_in = 0; step_in = 0; burst_in = 0; burst_len = 8'd0;
        #3;
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_step_mode", {31'd0, step_mode}, 32'd0);
        chk("rst_en_count", en_count, 32'd0);
        cyc(2);
        reset = 0;

        // 1: free run from the first edge after release
        cyc(1);
        chk("free_first", {31'd0, cpu_en}, 32'd1);
        cyc(10);
        chk("free_cnt10", en_count, 32'd10);

        // 2: one long step press -> one pulse, 6 edges after first high sample
        change_in = 1;
        cyc(12);
        base = int'(en_count);
        step_in = 1;
        highs = 0; first = -1;
        for (int j = 0; j < 25; j++) begin
            @(posedge clock); #2;
            if (cpu_en) begin
                highs++;
                if (first < 0) first = j;
            end
            if (j == 19) step_in = 0;
        end
        chk("step_pulses", highs, 32'd1);
        chk("step_latency", first, 32'd6);
        cyc(10);
        chk("step_cnt", en_count, base + 1);

        // 3: glitches shorter than the debounce window
        base = int'(en_count);
        repeat (4) begin
            step_in = 1; cyc(3);
            step_in = 0; cyc(3);
        end
        cyc(10);
        chk("glitch_cnt", en_count, base);

        // 4: burst of 5
        burst_len = 8'd5;
        base = int'(en_count);
        burst_in = 1;
        burst_window(20, 9, highs, bhigh, runs);
        chk("burst5_en", highs, 32'd5);
        chk("burst5_busy", bhigh, 32'd5);
        chk("burst5_runs", runs, 32'd1);
        chk("burst5_cnt", en_count, base + 5);

        // maximum burst length
        burst_len = 8'd255;
        burst_in = 1;
        burst_window(280, 7, highs, bhigh, runs);
        chk("burst255_en", highs, 32'd255);
        chk("burst255_runs", runs, 32'd1);

        // 5: abort a long burst by leaving step mode
        burst_len = 8'd200;
        burst_in = 1; cyc(8);
        burst_in = 0; cyc(42);
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        change_in = 0;
        lows = 0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clock); #2;
            if (!cpu_en) lows++;
        end
        chk("abort_en_lows", lows, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_mode", {31'd0, step_mode}, 32'd0);

        // zero-length burst is a no-op
        change_in = 1; cyc(12);
        burst_len = 8'd0;
        base = int'(en_count);
        burst_in = 1; cyc(8);
        burst_in = 0; cyc(10);
        chk("burst0_cnt", en_count, base);

        // 6: simultaneous step and burst -> burst only
        burst_len = 8'd3;
        base = int'(en_count);
        step_in = 1; burst_in = 1;
        burst_window(18, 7, highs, bhigh, runs);
        chk("both_en", highs, 32'd3);
        chk("both_cnt", en_count, base + 3);

        // async reset mid-burst drops outputs with no clock edge
        burst_len = 8'd100;
        burst_in = 1; cyc(8);
        burst_in = 0; cyc(5);
        @(negedge clock); #1;
        chk("mid_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1;
        #1;
        chk("arst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        cyc(2);
        reset = 0;
        cyc(15);

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            if (h_chg == 0) begin change_in = 1'($urandom_range(0, 1)); h_chg = $urandom_range(20, 200); end
            else h_chg--;
            if (h_stp == 0) begin step_in = 1'($urandom_range(0, 1)); h_stp = $urandom_range(1, 10); end
            else h_stp--;
            if (h_bst == 0) begin burst_in = 1'($urandom_range(0, 1)); h_bst = $urandom_range(1, 10); end
            else h_bst--;
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       burst_len = 8'd0;
                    1:       burst_len = 8'd255;
                    default: burst_len = 8'($urandom_range(1, 12));
                endcase
            end
            reset = ($urandom_range(0, 799) == 0);
            cyc(1);
        end
        reset = 0;
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
